// File: rtl/axil_desc_ram.sv
// axil_desc_ram: AXI4-Lite slave over a word-addressed scatter-gather descriptor RAM.
// Independent single-beat write and read FSMs; accesses outside the window return SLVERR.
module axil_desc_ram #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           MEM_DEPTH  = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_1000
) (
  input  logic                    S_AXI_aclk,
  input  logic                    S_AXI_areset,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_awaddr,
  input  logic [2:0]              S_AXI_awprot,
  input  logic                    S_AXI_awvalid,
  output logic                    S_AXI_awready,
  input  logic [DATA_WIDTH-1:0]   S_AXI_wdata,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_wstrb,
  input  logic                    S_AXI_wvalid,
  output logic                    S_AXI_wready,
  output logic [1:0]              S_AXI_bresp,
  output logic                    S_AXI_bvalid,
  input  logic                    S_AXI_bready,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_araddr,
  input  logic [2:0]              S_AXI_arprot,
  input  logic                    S_AXI_arvalid,
  output logic                    S_AXI_arready,
  output logic [DATA_WIDTH-1:0]   S_AXI_rdata,
  output logic [1:0]              S_AXI_rresp,
  output logic                    S_AXI_rvalid,
  input  logic                    S_AXI_rready
);

  localparam int          IW     = $clog2(MEM_DEPTH);
  localparam int          SW     = DATA_WIDTH / 8;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_DATA} rstate_e;

  wstate_e               wstate_q, wstate_d;
  rstate_e               rstate_q, rstate_d;
  logic                  en_q;
  logic                  acc_en;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [SW-1:0]         wstrb_q;
  logic [1:0]            bresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic                  aw_rdy, w_rdy, ar_rdy;
  logic                  aw_hs, w_hs, ar_hs;
  logic                  wr_commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [SW-1:0]         wr_strb;
  logic                  wr_hit, rd_hit;
  logic [IW-1:0]         wr_idx, rd_idx;
  logic                  unused_bits;

  // Handshakes are only offered from the first cycle after reset has been sampled low.
  always_ff @(posedge S_AXI_aclk) begin
    en_q <= ~S_AXI_areset;
  end

  assign acc_en = en_q & ~S_AXI_areset;
  assign aw_hs  = S_AXI_awvalid & aw_rdy;
  assign w_hs   = S_AXI_wvalid & w_rdy;
  assign ar_hs  = S_AXI_arvalid & ar_rdy;

  // Whichever half arrived first comes from its capture register.
  assign wr_addr = (wstate_q == W_ADDR) ? aw_addr_q : S_AXI_awaddr;
  assign wr_data = (wstate_q == W_DATA) ? wdata_q   : S_AXI_wdata;
  assign wr_strb = (wstate_q == W_DATA) ? wstrb_q   : S_AXI_wstrb;
  assign wr_hit  = (wr_addr[ADDR_WIDTH-1:IW+2] == BASE_ADDR[ADDR_WIDTH-1:IW+2]);
  assign wr_idx  = wr_addr[IW+1:2];
  assign rd_hit  = (S_AXI_araddr[ADDR_WIDTH-1:IW+2] == BASE_ADDR[ADDR_WIDTH-1:IW+2]);
  assign rd_idx  = S_AXI_araddr[IW+1:2];

  always_ff @(posedge S_AXI_aclk) begin
    if (S_AXI_areset) begin
      wstate_q <= W_IDLE;
      bresp_q  <= OKAY;
    end else begin
      wstate_q <= wstate_d;
      if (wr_commit) bresp_q <= wr_hit ? OKAY : SLVERR;
    end
  end

  always_ff @(posedge S_AXI_aclk) begin
    if (aw_hs) aw_addr_q <= S_AXI_awaddr;
    if (w_hs) begin
      wdata_q <= S_AXI_wdata;
      wstrb_q <= S_AXI_wstrb;
    end
  end

  always_comb begin
    wstate_d  = wstate_q;
    aw_rdy    = 1'b0;
    w_rdy     = 1'b0;
    wr_commit = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        aw_rdy = acc_en;
        w_rdy  = acc_en;
        if (acc_en && S_AXI_awvalid && S_AXI_wvalid) begin
          wstate_d  = W_RESP;
          wr_commit = 1'b1;
        end else if (acc_en && S_AXI_awvalid) begin
          wstate_d = W_ADDR;
        end else if (acc_en && S_AXI_wvalid) begin
          wstate_d = W_DATA;
        end
      end
      W_ADDR: begin
        w_rdy = acc_en;
        if (acc_en && S_AXI_wvalid) begin
          wstate_d  = W_RESP;
          wr_commit = 1'b1;
        end
      end
      W_DATA: begin
        aw_rdy = acc_en;
        if (acc_en && S_AXI_awvalid) begin
          wstate_d  = W_RESP;
          wr_commit = 1'b1;
        end
      end
      W_RESP: begin
        if (S_AXI_bready) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // RAM is not reset; byte lanes follow the strobes of the committing write.
  always_ff @(posedge S_AXI_aclk) begin
    if (wr_commit && wr_hit) begin
      for (int k = 0; k < SW; k++) begin
        if (wr_strb[k]) mem_q[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
      end
    end
  end

  always_ff @(posedge S_AXI_aclk) begin
    if (S_AXI_areset) begin
      rstate_q <= R_IDLE;
      rdata_q  <= '0;
      rresp_q  <= OKAY;
    end else begin
      rstate_q <= rstate_d;
      if (ar_hs) begin
        rdata_q <= rd_hit ? mem_q[rd_idx] : '0;
        rresp_q <= rd_hit ? OKAY : SLVERR;
      end
    end
  end

  always_comb begin
    rstate_d = rstate_q;
    ar_rdy   = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        ar_rdy = acc_en;
        if (acc_en && S_AXI_arvalid) rstate_d = R_DATA;
      end
      R_DATA: begin
        if (S_AXI_rready) rstate_d = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  assign S_AXI_awready = aw_rdy;
  assign S_AXI_wready  = w_rdy;
  assign S_AXI_arready = ar_rdy;
  assign S_AXI_bvalid  = (wstate_q == W_RESP) & ~S_AXI_areset;
  assign S_AXI_bresp   = bresp_q;
  assign S_AXI_rvalid  = (rstate_q == R_DATA) & ~S_AXI_areset;
  assign S_AXI_rdata   = rdata_q;
  assign S_AXI_rresp   = rresp_q;

  assign unused_bits = ^{S_AXI_awprot, S_AXI_arprot, wr_addr[1:0], S_AXI_araddr[1:0]};

endmodule

// File: tb/tb_axil_desc_ram.sv
// Testbench for axil_desc_ram: vector table, hand-written handshake sequences,
// and randomized traffic against a window/array reference model.
module tb_axil_desc_ram;

  logic        clk = 1'b0;
  logic        areset;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int errors = 0;
  int checks = 0;
  logic [31:0] model_mem [64];

  always #5 clk = ~clk;

  axil_desc_ram dut (
    .S_AXI_aclk(clk), .S_AXI_areset(areset),
    .S_AXI_awaddr(awaddr), .S_AXI_awprot(awprot), .S_AXI_awvalid(awvalid), .S_AXI_awready(awready),
    .S_AXI_wdata(wdata), .S_AXI_wstrb(wstrb), .S_AXI_wvalid(wvalid), .S_AXI_wready(wready),
    .S_AXI_bresp(bresp), .S_AXI_bvalid(bvalid), .S_AXI_bready(bready),
    .S_AXI_araddr(araddr), .S_AXI_arprot(arprot), .S_AXI_arvalid(arvalid), .S_AXI_arready(arready),
    .S_AXI_rdata(rdata), .S_AXI_rresp(rresp), .S_AXI_rvalid(rvalid), .S_AXI_rready(rready)
  );

  typedef struct {
    bit          do_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_bresp;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_rresp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit w, logic [31:0] a, logic [31:0] d, logic [3:0] s,
                              logic [1:0] eb, logic [31:0] er, logic [1:0] rr);
    vec_t v;
    v.do_wr = w; v.addr = a; v.data = d; v.strb = s;
    v.exp_bresp = eb; v.exp_rdata = er; v.exp_rresp = rr;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: the window is the 256-byte range starting at 0x1000.
  function automatic bit in_win(input logic [31:0] a);
    return (a >= 32'h0000_1000) && (a < 32'h0000_1100);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - 32'h0000_1000) >> 2);
  endfunction

  function automatic logic [31:0] init_val(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h0000_0101;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (in_win(a)) begin
      for (int k = 0; k < 4; k++)
        if (s[k]) model_mem[widx(a)][8*k +: 8] = d[8*k +: 8];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
    bit aw_p, w_p, fa, fw;
    int n;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    aw_p = 1'b1; w_p = 1'b1; n = 0;
    while ((aw_p || w_p) && n < 50) begin
      fa = awvalid && awready;
      fw = wvalid && wready;
      tick();
      n++;
      if (fa) begin awvalid = 1'b0; aw_p = 1'b0; end
      if (fw) begin wvalid = 1'b0; w_p = 1'b0; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    resp = 2'b11;
    if (aw_p || w_p) begin
      check("write_accept_timeout", 32'd1, 32'd0);
      return;
    end
    n = 0;
    while (!bvalid && n < 50) begin tick(); n++; end
    if (!bvalid) begin
      check("bvalid_timeout", 32'd1, 32'd0);
      return;
    end
    resp = bresp;
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    araddr = a; arvalid = 1'b1; n = 0;
    d = 32'hxxxx_xxxx; resp = 2'b11;
    while (!arready && n < 50) begin tick(); n++; end
    if (!arready) begin
      arvalid = 1'b0;
      check("ar_timeout", 32'd1, 32'd0);
      return;
    end
    tick();
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin tick(); n++; end
    if (!rvalid) begin
      check("rvalid_timeout", 32'd1, 32'd0);
      return;
    end
    d = rdata; resp = rresp;
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  task automatic wr_chk(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input string nm);
    logic [1:0] r;
    do_write(a, d, s, r);
    check(nm, 32'(r), in_win(a) ? 32'd0 : 32'd2);
    model_write(a, d, s);
  endtask

  task automatic rd_chk(input logic [31:0] a, input string nm);
    logic [31:0] d;
    logic [1:0]  r;
    do_read(a, d, r);
    check(nm, d, in_win(a) ? model_mem[widx(a)] : 32'd0);
    check({nm, "_rresp"}, 32'(r), in_win(a) ? 32'd0 : 32'd2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d, a, old;
    logic [1:0]  r;
    logic [3:0]  s;
    int          dd;

    areset = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", 32'({awready, wready, arready, bvalid, rvalid, bresp, rresp}), 32'd0);
    check("reset_rdata", rdata, 32'd0);
    areset = 1'b0;
    tick();
    check("ready_after_reset", 32'({awready, wready, arready, bvalid, rvalid}), 32'b11100);

    for (int i = 0; i < 64; i++) wr_chk(32'h1000 + 32'(i) * 4, init_val(i), 4'hF, "init_bresp");

    // Descriptor table: 4 descriptors x {NXTDESC, BUFADDR, CTRL} = 12 words 0x1000..0x10D8.
    for (int j = 0; j < 4; j++) begin
      dd = (j + 1) % 4;
      a  = 32'h1000 + 32'(dd) * 32'h40;
      tbl.push_back(mk(1, a,          32'h1000 + 32'((dd + 3) % 4) * 32'h40, 4'hF, 2'b00,
                       32'h1000 + 32'((dd + 3) % 4) * 32'h40, 2'b00));
      tbl.push_back(mk(1, a + 32'h08, 32'h8000_0000 + 32'(dd) * 32'h1000, 4'hF, 2'b00,
                       32'h8000_0000 + 32'(dd) * 32'h1000, 2'b00));
      tbl.push_back(mk(1, a + 32'h18, 32'h0C00_0000 | (32'(dd + 1) << 8), 4'hF, 2'b00,
                       32'h0C00_0000 | (32'(dd + 1) << 8), 2'b00));
    end
    tbl.push_back(mk(1, 32'h1018, 32'hFFFF_FFFF, 4'hF,    2'b00, 32'hFFFF_FFFF, 2'b00));
    tbl.push_back(mk(1, 32'h1018, 32'h1234_5678, 4'b0101, 2'b00, 32'hFF34_FF78, 2'b00));
    tbl.push_back(mk(1, 32'h0030, 32'hDEAD_BEEF, 4'hF,    2'b10, 32'h0000_0000, 2'b10));
    tbl.push_back(mk(0, 32'h1030, 32'h0,         4'h0,    2'b00, 32'hC0DE_0C0C, 2'b00));
    tbl.push_back(mk(1, 32'h1008, 32'hFFFF_FFFF, 4'h0,    2'b00, 32'h8000_0000, 2'b00));
    tbl.push_back(mk(1, 32'h10C8, 32'hAABB_CCDD, 4'b1010, 2'b00, 32'hAA00_CC00, 2'b00));
    tbl.push_back(mk(0, 32'h1042, 32'h0,         4'h0,    2'b00, 32'h0000_1000, 2'b00));
    tbl.push_back(mk(1, 32'h0FFC, 32'h5555_5555, 4'hF,    2'b10, 32'h0000_0000, 2'b10));
    tbl.push_back(mk(0, 32'h1100, 32'h0,         4'h0,    2'b00, 32'h0000_0000, 2'b10));

    foreach (tbl[i]) begin
      if (tbl[i].do_wr) begin
        do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, r);
        check($sformatf("tbl%0d_bresp", i), 32'(r), 32'(tbl[i].exp_bresp));
        model_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
      end
      do_read(tbl[i].addr, d, r);
      check($sformatf("tbl%0d_rdata", i), d, tbl[i].exp_rdata);
      check($sformatf("tbl%0d_rresp", i), 32'(r), 32'(tbl[i].exp_rresp));
    end

    // AW two cycles ahead of W, then a read on the edge right after the commit.
    awaddr = 32'h1050; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("waddr_state", 32'({awready, wready, bvalid}), 32'b010);
    tick();
    check("waddr_hold", 32'({awready, wready, bvalid}), 32'b010);
    wdata = 32'h5A5A_0001; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    check("aw_first_bvalid", 32'({bvalid, bresp}), 32'b100);
    model_write(32'h1050, 32'h5A5A_0001, 4'hF);
    bready = 1'b1; araddr = 32'h1050; arvalid = 1'b1;
    tick();
    bready = 1'b0; arvalid = 1'b0;
    check("aw_first_single_b", 32'(bvalid), 32'd0);
    check("read_after_commit", rdata, 32'h5A5A_0001);
    check("read_after_commit_vld", 32'(rvalid), 32'd1);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    tick();
    check("aw_first_no_extra_b", 32'(bvalid), 32'd0);

    // W three cycles ahead of AW.
    wdata = 32'h5A5A_0002; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) check("wdata_state", 32'({awready, wready, bvalid}), 32'b100);
    tick(); tick();
    check("wdata_hold", 32'({awready, wready, bvalid}), 32'b100);
    awaddr = 32'h1054; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("w_first_bvalid", 32'({bvalid, bresp}), 32'b100);
    model_write(32'h1054, 32'h5A5A_0002, 4'hF);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    tick();
    check("w_first_single_b", 32'(bvalid), 32'd0);
    rd_chk(32'h1054, "w_first_rdata");

    // Backpressure with a same-word read and write on one edge.
    old = model_mem[widx(32'h10C4)];
    awaddr = 32'h10C4; araddr = 32'h10C4; wdata = 32'h1111_2222; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    tick();
    awaddr = 32'h10E0; araddr = 32'h10E0; wdata = 32'h9999_9999;
    check("bp_pre_write_rdata", rdata, old);
    for (int i = 0; i < 5; i++) begin
      check("bp_valids", 32'({bvalid, rvalid, awready, wready, arready}), 32'b11000);
      check("bp_rdata_stable", rdata, old);
      check("bp_resp_stable", 32'({bresp, rresp}), 32'd0);
      tick();
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    check("bp_release", 32'({bvalid, rvalid}), 32'd0);
    model_write(32'h10C4, 32'h1111_2222, 4'hF);
    rd_chk(32'h10C4, "bp_new_data");
    rd_chk(32'h10E0, "bp_no_extra_write");

    // Reset while a write address is captured.
    awaddr = 32'h1060; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    areset = 1'b1;
    tick();
    check("midreset_outputs", 32'({awready, wready, arready, bvalid, rvalid}), 32'd0);
    areset = 1'b0;
    tick();
    check("midreset_idle", 32'({awready, wready, arready, bvalid}), 32'b1110);
    wdata = 32'h7777_0001; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    check("midreset_discard", 32'({awready, wready, bvalid}), 32'b100);
    awaddr = 32'h1064; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("midreset_write_b", 32'({bvalid, bresp}), 32'b100);
    model_write(32'h1064, 32'h7777_0001, 4'hF);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    rd_chk(32'h1064, "midreset_new");
    rd_chk(32'h1060, "midreset_untouched");

    // Randomized traffic against the model.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) != 0) a = 32'h1000 + 32'($urandom_range(0, 255));
      else begin
        a = $urandom;
        if (in_win(a)) a = a ^ 32'h8000_0000;
      end
      if ($urandom_range(0, 1) == 0) begin
        s = 4'($urandom_range(0, 15));
        wr_chk(a, $urandom, s, "rand_bresp");
      end else begin
        rd_chk(a, "rand_rdata");
      end
    end

    for (int i = 0; i < 64; i++) rd_chk(32'h1000 + 32'(i) * 4, "final_sweep");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axil_desc_ram.md
# axil_desc_ram

AXI4-Lite slave fronting a word-addressed descriptor RAM, mapped at the scatter-gather window and driven by the AXI-Lite stimulus master. It holds S2MM/MM2S SG descriptors: NXTDESC at +0x00, BUFADDR at +0x08, CTRL at +0x18, STAT at +0x1C, with descriptors on 0x40 strides. Every write and read is single-beat. Writes honour byte strobes. Out-of-window accesses return SLVERR.

## Interface
- DATA_WIDTH, 32, data bus width. Only 32 is supported.
- ADDR_WIDTH, 32, address bus width.
- MEM_DEPTH, 64, number of 32-bit words (256 bytes). Must be a power of two, at least 2.
- BASE_ADDR, 32'h0000_1000, window base. Aligned to MEM_DEPTH*4.
- S_AXI_aclk  in  1  the single clock.
- S_AXI_areset  in  1  reset, synchronous and active-high.
- S_AXI_awaddr  in  ADDR_WIDTH  write address.
- S_AXI_awprot  in  3  ignored.
- S_AXI_awvalid  in  1 / S_AXI_awready  out  1  write-address handshake.
- S_AXI_wdata  in  DATA_WIDTH  write data.
- S_AXI_wstrb  in  DATA_WIDTH/8  byte enables.
- S_AXI_wvalid  in  1 / S_AXI_wready  out  1  write-data handshake.
- S_AXI_bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
- S_AXI_bvalid  out  1 / S_AXI_bready  in  1  write-response handshake.
- S_AXI_araddr  in  ADDR_WIDTH  read address.
- S_AXI_arprot  in  3  ignored.
- S_AXI_arvalid  in  1 / S_AXI_arready  out  1  read-address handshake.
- S_AXI_rdata  out  DATA_WIDTH  read data.
- S_AXI_rresp  out  2  read response: 2'b00 OKAY, 2'b10 SLVERR.
- S_AXI_rvalid  out  1 / S_AXI_rready  in  1  read-data handshake.

## Operation
- IW = log2(MEM_DEPTH). Word index is addr[IW+1:2]. addr[1:0] is ignored.
- An address hits when addr[ADDR_WIDTH-1:IW+2] == BASE_ADDR[ADDR_WIDTH-1:IW+2]. Any other address misses.
- **Write FSM** states:
  - W_IDLE: awready=1, wready=1.
  - W_ADDR: address captured, waiting for data. wready=1, awready=0.
  - W_DATA: data captured, waiting for address. awready=1, wready=0.
  - W_RESP: bvalid=1.
- Write transitions:
  - AW and W in the same cycle: W_IDLE -> W_RESP.
  - AW only: W_IDLE -> W_ADDR.
  - W only: W_IDLE -> W_DATA.
  - W_ADDR -> W_RESP on W. W_DATA -> W_RESP on AW.
  - W_RESP -> W_IDLE on bready.
- Commit: RAM is updated on the clock edge where the second of AW/W completes.
  - Hit: RAM[idx] byte k <= wdata byte k for every wstrb[k]=1. bresp=OKAY.
  - Miss: RAM is unchanged. bresp=SLVERR.
- An all-zero wstrb on a hit leaves RAM unchanged and returns OKAY.
- **Read FSM** states:
  - R_IDLE: arready=1.
  - R_DATA: rvalid=1. rdata and rresp are held stable until rready.
- Read transitions: R_IDLE -> R_DATA on AR handshake. R_DATA -> R_IDLE on rready.
- Read data: hit returns RAM[idx] with OKAY. Miss returns 0 with SLVERR.
- Read and write paths are fully independent. They may be busy simultaneously.
- RAM contents are not cleared by reset.

## Timing
- Reset values, held during reset: awready=wready=arready=0, bvalid=rvalid=0, bresp=rresp=0, rdata=0. Both FSMs go to IDLE.
- The first cycle after reset deasserts: awready=wready=arready=1.
- Write latency, AW and W together: handshake on edge N; bvalid=1 after edge N; the earliest next AW/W handshake is on edge N+2, given bready=1 during N+1.
- Read latency: AR handshake on edge N; rvalid=1 with data after edge N; arready=0 while rvalid=1. Throughput is one read per 2 cycles.
- bvalid and rvalid, once high, stay high with stable payload until their ready is sampled high.
- A read and a write to the same word on the same edge return the pre-write data.
- A read accepted on the edge after a commit returns the new data.
- Reset mid-transaction abandons the transaction. No response is issued and a captured half-write (W_ADDR or W_DATA) is discarded.

## Test plan
- Reset release: all outputs are 0 during reset. One cycle after release, awready=wready=arready=1.
- Write 0x0000_1040 <- 0x0000_1000 (AW and W together, wstrb=4'hF), then read 0x0000_1040 -> rdata=0x0000_1000, rresp=OKAY, bresp=OKAY. Repeat the 12-word descriptor table at 0x1000..0x10D8 and read all 12 words back.
- AW two cycles before W, then W three cycles before AW -> each produces exactly one bvalid and the correct RAM word. awready and wready drop in the captured state.
- Partial strobe: 0x1018 <- 0xFFFF_FFFF, then 0x1018 <- 0x1234_5678 with wstrb=4'b0101 -> readback 0xFF34_FF78.
- Out-of-window write to 0x0000_0030 -> bresp=SLVERR. Reading 0x0000_0030 returns 0 with SLVERR, and readback of 0x1030 is unchanged.
- Backpressure: hold bready=0 and rready=0 for 5 cycles -> bvalid, rvalid and payloads stay stable with no extra handshakes accepted. Assert reset in W_ADDR -> the next write after reset behaves normally.
